// File: rtl/morse_rx_decoder_if.sv
// morse_rx_decoder_if
//   Bundles the Morse receiver's line input and decoded-letter outputs.
//   Signals:
//     morse_in  raw Morse line, high = mark (asynchronous to clk)
//     letter    decoded letter, 0 = A .. 25 = Z
//     valid     one-cycle strobe, letter updated
//     err       one-cycle strobe, malformed letter discarded
//     busy      decoder is not idle
//   Modports:
//     master    line source / letter consumer
//     slave     the decoder itself
interface morse_rx_decoder_if;
  logic       morse_in;
  logic [4:0] letter;
  logic       valid;
  logic       err;
  logic       busy;

  modport master (output morse_in, input letter, valid, err, busy);
  modport slave  (input morse_in, output letter, valid, err, busy);
endinterface

// File: rtl/morse_rx_decoder.sv
// morse_rx_decoder
//   Samples a serial Morse line, measures mark/space run lengths in clock
//   cycles, classifies marks as dot or dash and, at each letter gap, emits
//   the decoded letter with a one-cycle valid strobe (or a one-cycle err
//   strobe for malformed input).
//   Parameters:
//     UNIT_TICKS  clock cycles per Morse unit (>= 2, even)
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high
//     bus    morse_rx_decoder_if.slave (morse_in in; letter/valid/err/busy out)
//   Build option:
//     MORSE_RX_FULL_ALPHABET_EN  defined: A..Z decode; undefined: only A..H
//                                decode, other legal codes report err.
//
//   state | meaning
//   IDLE  | waiting for the first mark of a letter
//   MARK  | line high, timing a symbol
//   SPACE | line low between symbols, watching for the letter gap
//   ERROR | overlong mark seen, waiting for 2 units of continuous low
module morse_rx_decoder #(
  parameter int UNIT_TICKS = 25000000
) (
  input logic                clk,
  input logic                reset,
  morse_rx_decoder_if.slave  bus
);

  localparam int RUN_W = $clog2(3*UNIT_TICKS+2);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(3*UNIT_TICKS+1);
  localparam logic [RUN_W-1:0] LOW_END = RUN_W'(2*UNIT_TICKS);
  // Dash threshold compared against 2*L to avoid a fractional 1.5 units.
  localparam logic [RUN_W:0]   DASH_MIN2 = (RUN_W+1)'(3*UNIT_TICKS);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, ERROR} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             s_q, s_d;
  logic             s_last_q, s_last_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [3:0]       pat_q, pat_d;
  logic [2:0]       n_q, n_d;
  logic [4:0]       letter_q, letter_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic [5:0]       dec;
  logic             legal;
  logic             is_dash;

  // Returns {legal, letter}; the newest symbol sits in bit 0 of p.
  function automatic logic [5:0] decode(input logic [2:0] cnt, input logic [3:0] p);
    logic [5:0] r;
    r = 6'd0;
    case (cnt)
      3'd1: r = p[0] ? {1'b1, 5'd19} : {1'b1, 5'd4};
      3'd2:
        case (p[1:0])
          2'b00: r = {1'b1, 5'd8};
          2'b01: r = {1'b1, 5'd0};
          2'b10: r = {1'b1, 5'd13};
          default: r = {1'b1, 5'd12};
        endcase
      3'd3:
        case (p[2:0])
          3'b000: r = {1'b1, 5'd18};
          3'b001: r = {1'b1, 5'd20};
          3'b010: r = {1'b1, 5'd17};
          3'b011: r = {1'b1, 5'd22};
          3'b100: r = {1'b1, 5'd3};
          3'b101: r = {1'b1, 5'd10};
          3'b110: r = {1'b1, 5'd6};
          default: r = {1'b1, 5'd14};
        endcase
      3'd4:
        case (p)
          4'b0000: r = {1'b1, 5'd7};
          4'b0001: r = {1'b1, 5'd21};
          4'b0010: r = {1'b1, 5'd5};
          4'b0100: r = {1'b1, 5'd11};
          4'b0110: r = {1'b1, 5'd15};
          4'b0111: r = {1'b1, 5'd9};
          4'b1000: r = {1'b1, 5'd1};
          4'b1001: r = {1'b1, 5'd23};
          4'b1010: r = {1'b1, 5'd2};
          4'b1011: r = {1'b1, 5'd24};
          4'b1100: r = {1'b1, 5'd25};
          4'b1101: r = {1'b1, 5'd16};
          default: r = 6'd0;
        endcase
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    dec = decode(n_q, pat_q);
`ifdef MORSE_RX_FULL_ALPHABET_EN
    legal = dec[5];
`else
    legal = dec[5] && (dec[4:3] == 2'b00);
`endif
    is_dash = ({run_q, 1'b0} >= DASH_MIN2);
  end

  always_comb begin
    sync1_d  = bus.morse_in;
    s_d      = sync1_q;
    s_last_d = s_q;
    // run restarts at 1 whenever s differs from the previous sample.
    if (s_q != s_last_q)      run_d = RUN_W'(1);
    else if (run_q == RUN_MAX) run_d = run_q;
    else                       run_d = run_q + RUN_W'(1);

    state_d  = state_q;
    pat_d    = pat_q;
    n_d      = n_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_q) begin
          state_d = MARK;
          n_d     = 3'd0;
        end
      end
      MARK: begin
        if (s_q) begin
          if (run_d == RUN_MAX) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end else begin
          pat_d   = {pat_q[2:0], is_dash};
          n_d     = (n_q == 3'd5) ? 3'd5 : n_q + 3'd1;
          state_d = SPACE;
        end
      end
      SPACE: begin
        if (s_q) begin
          state_d = MARK;
        end else if (run_d == LOW_END) begin
          state_d = IDLE;
          if (legal) begin
            valid_d  = 1'b1;
            letter_d = dec[4:0];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ERROR: begin
        if (!s_q && run_d == LOW_END) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      s_last_q <= 1'b0;
      run_q    <= '0;
      pat_q    <= 4'd0;
      n_q      <= 3'd0;
      letter_q <= 5'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      s_q      <= s_d;
      s_last_q <= s_last_d;
      run_q    <= run_d;
      pat_q    <= pat_d;
      n_q      <= n_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign bus.letter = letter_q;
  assign bus.valid  = valid_q;
  assign bus.err    = err_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Directed bench for morse_rx_decoder with UNIT_TICKS = 4.
module tb_morse_rx_decoder;
  localparam int U = 4;
`ifdef MORSE_RX_FULL_ALPHABET_EN
  localparam bit FULL = 1'b1;
`else
  localparam bit FULL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  morse_rx_decoder_if bus();

  morse_rx_decoder #(.UNIT_TICKS(U)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe / letter monitor, sampled on the falling edge.
  int n_valid = 0, n_err = 0, n_both = 0, n_bad_letter = 0, n_long = 0;
  int last_strobe_cyc = 0;
  logic [4:0] prev_letter = 5'd0;
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_letter = bus.letter;
      prev_strobe = 1'b0;
    end else begin
      if (bus.valid) n_valid++;
      if (bus.err) n_err++;
      if (bus.valid || bus.err) last_strobe_cyc = cyc;
      if (bus.valid && bus.err) n_both++;
      if (bus.letter != prev_letter && !bus.valid) n_bad_letter++;
      if ((bus.valid || bus.err) && prev_strobe) n_long++;
      prev_strobe = bus.valid || bus.err;
      prev_letter = bus.letter;
    end
  end

  typedef struct {
    string      name;
    int         n;
    bit [5:0][3:0] m;
    int         gap;
    int         letter;   // -1 = not a legal Morse letter
  } vec_t;

  vec_t vecs[$];
  int edge_cyc;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input bit v, input int n);
    @(negedge clk);
    bus.morse_in = v;
    edge_cyc = cyc;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic add(input string name, input int n, input int a, input int b,
                     input int c, input int d, input int e, input int gap,
                     input int letter);
    vec_t v;
    v.name = name;
    v.n = n;
    v.m = '0;
    v.m[0] = 4'(a); v.m[1] = 4'(b); v.m[2] = 4'(c);
    v.m[3] = 4'(d); v.m[4] = 4'(e);
    v.gap = gap;
    v.letter = letter;
    vecs.push_back(v);
  endtask

  int cur_letter = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int v0, e0, rise, fall;
    bit ev;

    add("A",        2, 4, 8, 0, 0, 0, 4, 0);
    add("H",        4, 4, 4, 4, 4, 0, 4, 7);
    add("B",        4, 8, 4, 4, 4, 0, 4, 1);
    add("5dots",    5, 4, 4, 4, 4, 4, 4, -1);
    add("mark5_E",  1, 5, 0, 0, 0, 0, 4, 4);
    add("mark6_T",  1, 6, 0, 0, 0, 0, 4, 19);
    add("M",        2, 8, 8, 0, 0, 0, 4, 12);
    add("glitch_E", 1, 1, 0, 0, 0, 0, 4, 4);
    add("mark12_T", 1, 12, 0, 0, 0, 0, 4, 19);
    add("A_gap7",   2, 4, 8, 0, 0, 0, 7, 0);
    add("D",        3, 8, 4, 4, 0, 0, 4, 3);
    add("Z",        4, 8, 8, 4, 4, 0, 4, 25);
    add("bad..--",  4, 4, 4, 8, 8, 0, 4, -1);
    add("K",        3, 8, 4, 8, 0, 0, 4, 10);

    reset = 1'b1;
    bus.morse_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_letter", int'(bus.letter), 0);
    check("rst_valid",  int'(bus.valid), 0);
    check("rst_err",    int'(bus.err), 0);
    check("rst_busy",   int'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) begin
      v0 = n_valid;
      e0 = n_err;
      fall = 0;
      for (int k = 0; k < vecs[i].n; k++) begin
        hold(1'b1, int'(vecs[i].m[k]));
        if (k < vecs[i].n - 1) begin
          hold(1'b0, vecs[i].gap);
        end else begin
          hold(1'b0, 14);
          fall = edge_cyc + 0;
        end
      end
      #1;
      ev = (vecs[i].letter >= 0) && (FULL || vecs[i].letter < 8);
      if (ev) cur_letter = vecs[i].letter;
      check({vecs[i].name, "_valid"}, n_valid - v0, ev ? 1 : 0);
      check({vecs[i].name, "_err"},   n_err - e0,   ev ? 0 : 1);
      check({vecs[i].name, "_letter"}, int'(bus.letter), cur_letter);
      check({vecs[i].name, "_latency"}, last_strobe_cyc - fall, 2 + 2*U);
      check({vecs[i].name, "_busy"}, int'(bus.busy), 0);
    end

    // Overlong mark, then a high blip during the error wait restarts the low count.
    v0 = n_valid;
    e0 = n_err;
    hold(1'b1, 13);
    rise = edge_cyc;
    hold(1'b0, 5);
    hold(1'b1, 2);
    hold(1'b0, 5);
    #1;
    check("long_err", n_err - e0, 1);
    check("long_err_time", last_strobe_cyc - rise, 2 + 3*U + 1);
    check("long_wait_busy", int'(bus.busy), 1);
    hold(1'b0, 12);
    #1;
    check("long_idle_busy", int'(bus.busy), 0);
    check("long_no_valid", n_valid - v0, 0);
    check("long_err_once", n_err - e0, 1);
    check("long_letter", int'(bus.letter), cur_letter);

    // Reset in the middle of a mark.
    v0 = n_valid;
    e0 = n_err;
    hold(1'b1, 3);
    @(negedge clk);
    reset = 1'b1;
    bus.morse_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("midrst_letter", int'(bus.letter), 0);
    check("midrst_valid",  int'(bus.valid), 0);
    check("midrst_err",    int'(bus.err), 0);
    check("midrst_busy",   int'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("midrst_no_strobe", (n_valid - v0) + (n_err - e0), 0);
    check("midrst_letter_after", int'(bus.letter), 0);
    v0 = n_valid;
    for (int k = 0; k < 4; k++) begin
      hold(1'b1, 4);
      hold(1'b0, (k < 3) ? 4 : 14);
    end
    fall = edge_cyc;
    #1;
    check("post_rst_H_valid", n_valid - v0, 1);
    check("post_rst_H_letter", int'(bus.letter), 7);
    check("post_rst_H_latency", last_strobe_cyc - fall, 2 + 2*U);

    check("valid_and_err_together", n_both, 0);
    check("letter_changed_without_valid", n_bad_letter, 0);
    check("strobe_longer_than_1", n_long, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
